// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch and data access.
// Data access wins ties; a starvation counter forces a fetch grant after STARVE_MAX lost ties.
//
//  state  | meaning
//  IDLE   | arbitration slot; latch the winner's request into mem_*
//  ACCESS | memory busy for MEM_LAT cycles, mem_en only in the first one
//  RESP   | one-cycle valid pulse to the owning requester
module unified_mem_arbiter #(
    parameter int D_SIZE     = 32,
    parameter int AD_SIZE    = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [AD_SIZE-1:0] if_addr,
    output logic [D_SIZE-1:0]  if_rdata,
    output logic               if_valid,
    output logic               if_stall,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [AD_SIZE-1:0] dm_addr,
    input  logic [D_SIZE-1:0]  dm_wdata,
    output logic [D_SIZE-1:0]  dm_rdata,
    output logic               dm_valid,
    output logic               dm_stall,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AD_SIZE-1:0] mem_addr,
    output logic [D_SIZE-1:0]  mem_wdata,
    input  logic [D_SIZE-1:0]  mem_rdata,
    output logic [1:0]         owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_DM   = 2'b10;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       cur_we;
    logic       grant_if;
    logic       grant_dm;

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == S_IDLE) begin
            if (dm_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            cur_we     <= 1'b0;
            owner      <= OWN_NONE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!if_req) begin
                        starve_cnt <= 4'd0;
                    end
                    if (grant_if) begin
                        owner      <= OWN_IF;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        cur_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        starve_cnt <= 4'd0;
                        lat_cnt    <= LAT_INIT;
                        state      <= S_ACCESS;
                    end else if (grant_dm) begin
                        owner     <= OWN_DM;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        cur_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        // Only a tie can get here with if_req high, so the count stays <= STARVE_MAX.
                        if (if_req) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        lat_cnt <= LAT_INIT;
                        state   <= S_ACCESS;
                    end else begin
                        owner <= OWN_NONE;
                    end
                end

                S_ACCESS: begin
                    if (lat_cnt == 4'd1) begin
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!cur_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_valid <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    owner <= OWN_NONE;
                    state <= S_IDLE;
                end

                default: begin
                    owner <= OWN_NONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: stimulus pushes expected memory strobes and
// responses into queues; a negedge monitor pops and compares them as the DUT produces them.
module tb_unified_mem_arbiter;

    localparam int D_SIZE  = 32;
    localparam int AD_SIZE = 32;
    localparam int MEM_LAT = 2;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wdata;
        logic [1:0]  own;
        int          cyc;
    } memx_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               if_req;
    logic [AD_SIZE-1:0] if_addr;
    logic [D_SIZE-1:0]  if_rdata;
    logic               if_valid;
    logic               if_stall;
    logic               dm_req;
    logic               dm_we;
    logic [AD_SIZE-1:0] dm_addr;
    logic [D_SIZE-1:0]  dm_wdata;
    logic [D_SIZE-1:0]  dm_rdata;
    logic               dm_valid;
    logic               dm_stall;
    logic               mem_en;
    logic               mem_we;
    logic [AD_SIZE-1:0] mem_addr;
    logic [D_SIZE-1:0]  mem_wdata;
    logic [D_SIZE-1:0]  mem_rdata = '0;
    logic [1:0]         owner;

    resp_t resp_q[$];
    memx_t memx_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    logic [31:0] mem_model [0:63];

    unified_mem_arbiter #(
        .D_SIZE(D_SIZE), .AD_SIZE(AD_SIZE), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] preload(input int i);
        case (i)
            4:       return 32'h2002_0005;  // 0x10
            5:       return 32'h3C1D_0004;  // 0x14
            6:       return 32'h0BAD_F00D;  // 0x18
            8:       return 32'h8C22_0008;  // 0x20
            16:      return 32'h1111_2222;  // 0x40
            32:      return 32'h0000_ABCD;  // 0x80
            33:      return 32'h1234_5678;  // 0x84
            default: return 32'hA5A5_0000 | 32'(i);
        endcase
    endfunction

    // Memory model: read data appears the cycle after mem_en and holds; read-before-write.
    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = preload(i);
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1) begin
                mem_rdata <= mem_model[mem_addr[7:2]];
                if (mem_we === 1'b1) mem_model[mem_addr[7:2]] = mem_wdata;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit chk, input logic [1:0] own, input int c);
        memx_t m;
        m.we = we; m.addr = addr; m.wdata = wdata; m.chk_wdata = chk; m.own = own; m.cyc = c;
        memx_q.push_back(m);
    endtask

    task automatic push_resp(input bit is_if, input logic [31:0] data, input int c);
        resp_t r;
        r.is_if = is_if; r.data = data; r.cyc = c;
        resp_q.push_back(r);
    endtask

    task automatic wait_valid(input bit is_if, input int budget);
        int n = 0;
        while (!((is_if ? if_valid : dm_valid) === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("valid_wait", 32'(is_if ? if_valid : dm_valid), 32'd1);
    endtask

    // Monitor
    initial begin
        memx_t m;
        resp_t r;
        bit    prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                check("valid_excl", 32'(if_valid & dm_valid), 32'd0);
                check("mem_en_gap", 32'(prev_en & mem_en), 32'd0);
            end
            if (mem_en === 1'b1) begin
                if (memx_q.size() == 0) begin
                    check("mem_en_expected", 32'(memx_q.size()), 32'd1);
                end else begin
                    m = memx_q.pop_front();
                    check("mem_cycle", 32'(cyc), 32'(m.cyc));
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_addr", mem_addr, m.addr);
                    if (m.chk_wdata) check("mem_wdata", mem_wdata, m.wdata);
                    check("owner", 32'(owner), 32'(m.own));
                end
            end
            if (if_valid === 1'b1 || dm_valid === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("valid_expected", 32'(resp_q.size()), 32'd1);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_src", 32'(if_valid), 32'(r.is_if));
                    check("resp_cycle", 32'(cyc), 32'(r.cyc));
                    check("resp_data", r.is_if ? if_rdata : dm_rdata, r.data);
                end
            end
            prev_en = (mem_en === 1'b1) && (rst === 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [31:0] exp_dm;

        // 1: reset with both requests high
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {27'd0, mem_en, mem_we, if_valid, owner}, 32'd0);
        check("rst_dm_valid", 32'(dm_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        rst = 1'b0; if_req = 1'b0;
        c0 = cyc;
        push_mem(1'b0, 32'h80, 32'h0, 1'b0, 2'b10, c0 + 1);
        push_resp(1'b0, 32'h0000_ABCD, c0 + 3);
        exp_dm = 32'h0000_ABCD;
        wait_valid(1'b0, 10);
        dm_req = 1'b0;

        // 2: single fetch with stall profile
        repeat (2) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        c0 = cyc;
        push_mem(1'b0, 32'h10, 32'h0, 1'b0, 2'b01, c0 + 1);
        push_resp(1'b1, 32'h2002_0005, c0 + 3);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("if_stall", 32'(if_stall), (k < 3) ? 32'd1 : 32'd0);
            if (k < 3) @(negedge clk);
        end
        if_req = 1'b0;

        // 3: simultaneous requests, data first
        repeat (2) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h14;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        c0 = cyc;
        push_mem(1'b0, 32'h80, 32'h0, 1'b0, 2'b10, c0 + 1);
        push_resp(1'b0, 32'h0000_ABCD, c0 + 3);
        push_mem(1'b0, 32'h14, 32'h0, 1'b0, 2'b01, c0 + 5);
        push_resp(1'b1, 32'h3C1D_0004, c0 + 7);
        wait_valid(1'b0, 10);
        dm_req = 1'b0;
        wait_valid(1'b1, 12);
        if_req = 1'b0;

        // 4: starvation guard, both held for six transactions
        repeat (2) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h18;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h84;
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            push_mem(1'b0, (k == 4) ? 32'h18 : 32'h84, 32'h0, 1'b0,
                     (k == 4) ? 2'b01 : 2'b10, c0 + 4 * k + 1);
            push_resp(k == 4, (k == 4) ? 32'h0BAD_F00D : 32'h1234_5678, c0 + 4 * k + 3);
        end
        exp_dm = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            wait_valid(k == 4, 8);
            if (k < 5) @(negedge clk);
        end
        if_req = 1'b0; dm_req = 1'b0;

        // 5: store, then read it back
        repeat (2) @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        c0 = cyc;
        push_mem(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 2'b10, c0 + 1);
        push_resp(1'b0, exp_dm, c0 + 3);
        #1 check("dm_stall", 32'(dm_stall), 32'd1);
        wait_valid(1'b0, 10);
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h40;
        c0 = cyc;
        push_mem(1'b0, 32'h40, 32'h0, 1'b0, 2'b10, c0 + 1);
        push_resp(1'b0, 32'hDEAD_BEEF, c0 + 3);
        wait_valid(1'b0, 10);
        dm_req = 1'b0;

        // 6: reset in the second ACCESS cycle of a fetch
        repeat (2) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        c0 = cyc;
        push_mem(1'b0, 32'h10, 32'h0, 1'b0, 2'b01, c0 + 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_if_valid", 32'(if_valid), 32'd0);
        check("midrst_owner", 32'(owner), 32'd0);
        check("midrst_if_rdata", if_rdata, 32'd0);
        rst = 1'b0; if_addr = 32'h20;
        c0 = cyc;
        push_mem(1'b0, 32'h20, 32'h0, 1'b0, 2'b01, c0 + 1);
        push_resp(1'b1, 32'h8C22_0008, c0 + 3);
        wait_valid(1'b1, 10);
        if_req = 1'b0;

        repeat (4) @(negedge clk);
        check("resp_q_left", 32'(resp_q.size()), 32'd0);
        check("memx_q_left", 32'(memx_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Sequences a single-port, fixed-latency memory and shares it between two requesters: instruction fetch (IF) and data memory access (DM).
- Sits between the IF-stage fetch logic and the MEM-stage load/store logic, and the single memory macro behind them.
- Drives per-requester stall lines that feed the pipeline PC_write/ID_write hazard controls.
- Arbitration is data-priority with a starvation guard for fetch.

Parameters:
D_SIZE, 32, data width of memory words and requester data buses
AD_SIZE, 32, address width
MEM_LAT, 2, cycles from the mem_en cycle to the edge where mem_rdata is sampled (legal range 1..8)
STARVE_MAX, 4, maximum consecutive DM grants while if_req is pending before IF is forced to win (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request (level; held until if_valid)
if_addr  input  AD_SIZE  fetch address
if_rdata  output  D_SIZE  registered fetch data
if_valid  output  1  one-cycle completion pulse for fetch
if_stall  output  1  if_req & ~if_valid (combinational)
dm_req  input  1  data request (level; held until dm_valid)
dm_we  input  1  1 = store, 0 = load
dm_addr  input  AD_SIZE  data address
dm_wdata  input  D_SIZE  store data
dm_rdata  output  D_SIZE  registered load data
dm_valid  output  1  one-cycle completion pulse for data
dm_stall  output  1  dm_req & ~dm_valid (combinational)
mem_en  output  1  memory access strobe, exactly one cycle per transaction
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  AD_SIZE  memory address (registered)
mem_wdata  output  D_SIZE  memory write data (registered)
mem_rdata  input  D_SIZE  memory read data
owner  output  2  current grant: 00 none, 01 IF, 10 DM

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - if_rdata, dm_rdata = 0; if_valid, dm_valid = 0.
  - owner=00; starvation counter = 0.
- FSM states:
  - IDLE
    - No request: remain in IDLE; owner=00.
    - At least one request: pick the winner, register its addr/wdata/we into mem_*, set owner, go to ACCESS with the cycle counter loaded to MEM_LAT.
  - ACCESS
    - mem_en=1 in the first ACCESS cycle only.
    - mem_we = winner's we; forced to 0 for IF.
    - Counter decrements each cycle.
    - At the edge ending the MEM_LAT-th ACCESS cycle:
      - On a read, capture mem_rdata into the owner's rdata register.
      - Go to RESP.
  - RESP (one cycle)
    - Owner's valid=1.
    - Next state IDLE; owner returns to 00 in IDLE.
- Latency and throughput:
  - Request sampled in IDLE cycle 0 → mem_en in cycle 1 → valid in cycle MEM_LAT+1.
  - One transaction per MEM_LAT+2 cycles; the mandatory IDLE cycle is the arbitration slot.
- Arbitration:
  - Only DM requesting: DM wins.
  - Only IF requesting: IF wins.
  - Both requesting, starvation counter < STARVE_MAX: DM wins and the counter increments.
  - Both requesting, counter == STARVE_MAX: IF wins.
  - Counter clears on any IF grant and on any IDLE cycle where if_req=0. It saturates at STARVE_MAX.
- Stores:
  - dm_valid pulses in RESP as a write acknowledge.
  - dm_rdata keeps its previous value; mem_rdata is ignored.
- Request deasserted mid-transaction: the transaction still completes and the valid pulse is still issued. Requesters must hold req/addr/wdata stable until their valid pulse.
- Request still asserted in the valid cycle: treated as a new request at the next IDLE arbitration.
- Addresses and data pass through unmodified; no width conversion and no alignment checks.
- Reset mid-transaction:
  - Immediate return to IDLE; no valid pulse is issued.
  - A store whose mem_en cycle already occurred is considered performed; one not yet issued is dropped.
- Valids are mutually exclusive and never asserted outside RESP.
- mem_en is never high for two consecutive cycles.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with both reqs high → all outputs 0 and owner=00; after release, first mem_en is no earlier than 1 cycle after the first IDLE sample.
2. Single fetch (MEM_LAT=2):
   - Stimulus: if_req=1, if_addr=0x00000010; memory model returns 0x20020005.
   - Required: mem_en=1, mem_we=0, mem_addr=0x10 in cycle 1; if_valid=1, if_rdata=0x20020005 in cycle 3; if_stall=1 in cycles 0–2 and 0 in cycle 3.
3. Simultaneous requests:
   - Stimulus: if_req=1 (0x14) and dm_req=1 load (0x80→0x0000ABCD) in the same cycle.
   - Required: DM granted first; dm_valid with dm_rdata=0x0000ABCD in cycle 3; then IF mem_en in cycle 5 and if_valid in cycle 7.
4. Starvation (STARVE_MAX=4): both reqs held continuously for 6 transactions → owner sequence DM, DM, DM, DM, IF, DM.
5. Store:
   - Stimulus: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF.
   - Required: one mem_en cycle with mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; dm_valid pulse; dm_rdata unchanged from its prior value.
6. Reset mid-ACCESS: assert rst in the second ACCESS cycle of a fetch → no if_valid, state IDLE, if_rdata=0; a fetch after reset completes normally with full latency.
